muldiv_unit: RTL and testbench

Iterative multiply/divide unit with HI/LO registers for the 5-stage MIPS pipeline. It sits beside the EX-stage ALU and takes the forwarded Rs/Rt operands (after the forward muxes) plus a decoded op from the ID/EX control bundle. It supplies HI/LO to the EX result path for MFHI/MFLO. It raises a stall request to the hazard unit while an operation is in flight.

---
 rtl/muldiv_pkg.sv | 21 ++
 rtl/muldiv_step.sv | 33 +++
 rtl/muldiv_unit.sv | 155 +++++++++++++++
 tb/tb_muldiv_unit.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/muldiv_pkg.sv
// Shared constants and types for the iterative multiply/divide unit.
// Op codes follow the ID/EX control bundle encoding.
package muldiv_pkg;

  localparam int DEF_WIDTH = 32;
  localparam int DEF_ITER  = 32;

  localparam logic [2:0] OP_MULT  = 3'd0;
  localparam logic [2:0] OP_MULTU = 3'd1;
  localparam logic [2:0] OP_DIV   = 3'd2;
  localparam logic [2:0] OP_DIVU  = 3'd3;
  localparam logic [2:0] OP_MTHI  = 3'd4;
  localparam logic [2:0] OP_MTLO  = 3'd5;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_FIX  = 2'd2
  } state_t;

endpackage

// File: rtl/muldiv_step.sv
// One radix-2 iteration: shift-add multiply or restoring divide.
// Accumulator is {hi_part, lo_part}; lo_part holds multiplier or dividend.
module muldiv_step
  import muldiv_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic                 i_mul,
  input  logic [2*WIDTH-1:0]   i_acc,
  input  logic [WIDTH-1:0]     i_opnd,
  output logic [2*WIDTH-1:0]   o_acc
);

  logic [WIDTH:0] w_sum;
  logic [WIDTH:0] w_diff;
  logic           w_ge;

  always_comb begin
    w_sum  = {1'b0, i_acc[2*WIDTH-1:WIDTH]}
           + (i_acc[0] ? {1'b0, i_opnd} : {(WIDTH+1){1'b0}});
    // partial remainder stays below divisor, so a clear top bit means no borrow
    w_diff = i_acc[2*WIDTH-1:WIDTH-1] - {1'b0, i_opnd};
    w_ge   = ~w_diff[WIDTH];
    if (i_mul) begin
      o_acc = {w_sum, i_acc[WIDTH-1:1]};
    end else if (w_ge) begin
      o_acc = {w_diff[WIDTH-1:0], i_acc[WIDTH-2:0], 1'b1};
    end else begin
      o_acc = {i_acc[2*WIDTH-2:0], 1'b0};
    end
  end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative MULT/DIV unit with HI/LO registers beside the EX-stage ALU.
// Magnitudes are iterated; signs are restored in a single FIX cycle.
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int ITER  = DEF_ITER
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cancel,
  input  logic             hilo_rd,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             busy,
  output logic             done,
  output logic             stall
);

  localparam int CW = $clog2(ITER);

  state_t             r_state;
  state_t             w_next;
  logic [CW-1:0]      r_cnt;
  logic [2*WIDTH-1:0] r_acc;
  logic [2*WIDTH-1:0] w_step;
  logic [WIDTH-1:0]   r_opnd;
  logic [WIDTH-1:0]   r_a;
  logic [WIDTH-1:0]   r_hi;
  logic [WIDTH-1:0]   r_lo;
  logic               r_mul;
  logic               r_neg_q;
  logic               r_neg_r;
  logic               r_bzero;
  logic               r_done;

  logic               w_idle;
  logic               w_mop;
  logic               w_go;
  logic               w_signed;
  logic               w_sa;
  logic               w_sb;
  logic [WIDTH-1:0]   w_aabs;
  logic [WIDTH-1:0]   w_babs;
  logic [2*WIDTH-1:0] w_prod;
  logic [WIDTH-1:0]   w_q;
  logic [WIDTH-1:0]   w_r;

  muldiv_step #(.WIDTH(WIDTH)) u_step (
    .i_mul  (r_mul),
    .i_acc  (r_acc),
    .i_opnd (r_opnd),
    .o_acc  (w_step)
  );

  always_comb begin
    w_idle   = (r_state == S_IDLE);
    w_mop    = start & (op <= OP_DIVU);
    w_go     = w_idle & w_mop & ~cancel;
    w_signed = (op == OP_MULT) | (op == OP_DIV);
    w_sa     = w_signed & a[WIDTH-1];
    w_sb     = w_signed & b[WIDTH-1];
    w_aabs   = w_sa ? (~a + 1'b1) : a;
    w_babs   = w_sb ? (~b + 1'b1) : b;
    w_prod   = r_neg_q ? (~r_acc + 1'b1) : r_acc;
    w_q      = r_neg_q ? (~r_acc[WIDTH-1:0] + 1'b1)
                       : r_acc[WIDTH-1:0];
    w_r      = r_neg_r ? (~r_acc[2*WIDTH-1:WIDTH] + 1'b1)
                       : r_acc[2*WIDTH-1:WIDTH];
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE: if (w_go) w_next = S_CALC;
      S_CALC: begin
        if (cancel) w_next = S_IDLE;
        else if (r_cnt == CW'(ITER-1)) w_next = S_FIX;
      end
      S_FIX:   w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt   <= '0;
      r_acc   <= '0;
      r_opnd  <= '0;
      r_a     <= '0;
      r_hi    <= '0;
      r_lo    <= '0;
      r_mul   <= 1'b0;
      r_neg_q <= 1'b0;
      r_neg_r <= 1'b0;
      r_bzero <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      unique case (r_state)
        S_IDLE: begin
          if (w_go) begin
            r_cnt   <= '0;
            r_mul   <= ~op[1];
            r_neg_q <= w_sa ^ w_sb;
            r_neg_r <= w_sa;
            r_bzero <= (b == '0);
            r_a     <= a;
            r_acc   <= {{WIDTH{1'b0}}, op[1] ? w_aabs : w_babs};
            r_opnd  <= op[1] ? w_babs : w_aabs;
          end else if (start && !cancel && op == OP_MTHI) begin
            r_hi <= a;
          end else if (start && !cancel && op == OP_MTLO) begin
            r_lo <= a;
          end
        end
        S_CALC: begin
          r_acc <= w_step;
          r_cnt <= r_cnt + 1'b1;
        end
        S_FIX: begin
          if (!cancel) begin
            if (r_mul) begin
              {r_hi, r_lo} <= w_prod;
            end else if (r_bzero) begin
              r_hi <= r_a;
              r_lo <= '1;
            end else begin
              r_hi <= w_r;
              r_lo <= w_q;
            end
            r_done <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign hi    = r_hi;
  assign lo    = r_lo;
  assign busy  = ~w_idle;
  assign done  = r_done;
  assign stall = busy | (w_mop & w_idle) | (hilo_rd & (busy | start));

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: directed table, corner sequences,
// and random operations against an arithmetic reference model.
module tb_muldiv_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [2:0]  op = 3'd0;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic        cancel = 1'b0;
  logic        hilo_rd = 1'b0;
  logic [31:0] hi;
  logic [31:0] lo;
  logic        busy;
  logic        done;
  logic        stall;

  int checks = 0;
  int failures = 0;

  muldiv_unit dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .op      (op),
    .a       (a),
    .b       (b),
    .cancel  (cancel),
    .hilo_rd (hilo_rd),
    .hi      (hi),
    .lo      (lo),
    .busy    (busy),
    .done    (done),
    .stall   (stall)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (!rst && busy && start) begin
      failures++;
      $display("FAIL start_while_busy time=%0t", $time);
    end
  end

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] ehi;
    logic [31:0] elo;
  } vec_t;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", nm, act, exp);
    end
  endtask

  function automatic logic [63:0] model(input logic [2:0] o,
                                        input logic [31:0] x,
                                        input logic [31:0] y);
    longint sp;
    int     sq;
    int     sr;
    logic [63:0] r;
    r = '0;
    case (o)
      3'd0: begin
        sp = longint'($signed(x)) * longint'($signed(y));
        r  = sp;
      end
      3'd1: r = {32'd0, x} * {32'd0, y};
      3'd2: begin
        if (y == 0) r = {x, 32'hFFFFFFFF};
        else if (x == 32'h80000000 && y == 32'hFFFFFFFF)
          r = {32'd0, 32'h80000000};
        else begin
          sq = $signed(x) / $signed(y);
          sr = $signed(x) % $signed(y);
          r  = {sr, sq};
        end
      end
      3'd3: begin
        if (y == 0) r = {x, 32'hFFFFFFFF};
        else r = {x % y, x / y};
      end
      default: r = '0;
    endcase
    return r;
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Called at posedge+1 with the unit idle.
  task automatic run_op(input logic [2:0] o, input logic [31:0] xa,
                        input logic [31:0] xb, input logic [63:0] e,
                        input string nm);
    int n;
    logic [63:0] prev;
    logic partial;
    logic nostall;
    prev = {hi, lo};
    partial = 1'b0;
    nostall = 1'b0;
    start = 1'b1;
    op = o;
    a = xa;
    b = xb;
    tick();
    start = 1'b0;
    n = 0;
    while (busy && n < 40) begin
      if ({hi, lo} !== prev) partial = 1'b1;
      if (!stall || done) nostall = 1'b1;
      n++;
      a = $urandom;
      b = $urandom;
      tick();
    end
    chk({nm, ".busy_cycles"}, 64'(n), 64'd33);
    chk({nm, ".no_partial"}, {63'd0, partial}, 64'd0);
    chk({nm, ".stall_busy"}, {63'd0, nostall}, 64'd0);
    chk({nm, ".done"}, {63'd0, done}, 64'd1);
    chk({nm, ".hilo"}, {hi, lo}, e);
    tick();
    chk({nm, ".done_off"}, {63'd0, done}, 64'd0);
  endtask

  vec_t tv[10];

  initial begin
    logic [2:0]  ro;
    logic [31:0] ra;
    logic [31:0] rb;
    int n;
    logic bad;

    tv[0] = '{3'd0, 32'hFFFFFFFE, 32'd3, 32'hFFFFFFFF, 32'hFFFFFFFA};
    tv[1] = '{3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h1};
    tv[2] = '{3'd2, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD};
    tv[3] = '{3'd3, 32'd7, 32'd2, 32'd1, 32'd3};
    tv[4] = '{3'd3, 32'd5, 32'd0, 32'd5, 32'hFFFFFFFF};
    tv[5] = '{3'd2, 32'h80000000, 32'hFFFFFFFF, 32'd0, 32'h80000000};
    tv[6] = '{3'd2, 32'd7, 32'hFFFFFFFE, 32'd1, 32'hFFFFFFFD};
    tv[7] = '{3'd2, 32'hFFFFFFF9, 32'd0, 32'hFFFFFFF9, 32'hFFFFFFFF};
    tv[8] = '{3'd0, 32'h80000000, 32'h80000000, 32'h40000000, 32'h0};
    tv[9] = '{3'd1, 32'h10000, 32'h10000, 32'h1, 32'h0};

    tick();
    tick();
    chk("rst.hi", 64'(hi), 64'd0);
    chk("rst.lo", 64'(lo), 64'd0);
    chk("rst.busy", 64'(busy), 64'd0);
    chk("rst.done", 64'(done), 64'd0);
    chk("rst.stall", 64'(stall), 64'd0);
    rst = 1'b0;
    tick();

    start = 1'b1; op = 3'd4; a = 32'h11;
    #1;
    chk("mthi.stall", 64'(stall), 64'd0);
    tick();
    chk("mthi.hi", 64'(hi), 64'h11);
    chk("mthi.busy", 64'(busy), 64'd0);
    chk("mthi.done", 64'(done), 64'd0);
    op = 3'd5; a = 32'h22;
    tick();
    start = 1'b0;
    chk("mtlo.lo", 64'(lo), 64'h22);
    chk("mtlo.hi", 64'(hi), 64'h11);
    chk("mtlo.busy", 64'(busy), 64'd0);
    chk("mtlo.done", 64'(done), 64'd0);

    start = 1'b1; cancel = 1'b1; op = 3'd4; a = 32'h99;
    tick();
    chk("cancel_mthi.hi", 64'(hi), 64'h11);
    op = 3'd0; a = 32'd3; b = 32'd4;
    tick();
    start = 1'b0; cancel = 1'b0;
    chk("cancel_mult.busy", 64'(busy), 64'd0);
    tick();
    chk("cancel_mult.done", 64'(done), 64'd0);

    start = 1'b1; op = 3'd6; a = 32'h55; b = 32'h66;
    #1;
    chk("rsvd.stall", 64'(stall), 64'd0);
    tick();
    op = 3'd7;
    tick();
    start = 1'b0;
    chk("rsvd.busy", 64'(busy), 64'd0);
    chk("rsvd.hilo", {hi, lo}, {32'h11, 32'h22});

    start = 1'b1; op = 3'd0; a = 32'd3; b = 32'd5;
    tick();
    start = 1'b0;
    repeat (9) tick();
    chk("cancel10.busy_before", 64'(busy), 64'd1);
    cancel = 1'b1;
    tick();
    cancel = 1'b0;
    chk("cancel10.busy", 64'(busy), 64'd0);
    chk("cancel10.hilo", {hi, lo}, {32'h11, 32'h22});
    chk("cancel10.done", 64'(done), 64'd0);
    tick();
    chk("cancel10.done2", 64'(done), 64'd0);

    start = 1'b1; op = 3'd3; a = 32'd100; b = 32'd7; hilo_rd = 1'b1;
    #1;
    chk("hilord.stall_start", 64'(stall), 64'd1);
    tick();
    start = 1'b0;
    n = 0;
    bad = 1'b0;
    while (busy && n < 40) begin
      #1;
      if (!stall) bad = 1'b1;
      n++;
      tick();
    end
    #1;
    chk("hilord.cycles", 64'(n), 64'd33);
    chk("hilord.stall_calc", 64'(bad), 64'd0);
    chk("hilord.done", 64'(done), 64'd1);
    chk("hilord.stall_done", 64'(stall), 64'd0);
    chk("hilord.hilo", {hi, lo}, {32'd2, 32'd14});
    hilo_rd = 1'b0;
    tick();

    for (int i = 0; i < 10; i++) begin
      run_op(tv[i].op, tv[i].a, tv[i].b, {tv[i].ehi, tv[i].elo},
             $sformatf("vec%0d", i));
    end

    for (int i = 0; i < 24; i++) begin
      ro = 3'($urandom_range(0, 3));
      ra = $urandom;
      rb = $urandom;
      case ($urandom_range(0, 5))
        0: rb = 32'd0;
        1: rb = 32'($urandom_range(1, 15));
        2: ra = 32'h80000000;
        default: ;
      endcase
      run_op(ro, ra, rb, model(ro, ra, rb), $sformatf("rnd%0d", i));
    end

    start = 1'b1; op = 3'd4; a = 32'h33;
    tick();
    op = 3'd0; a = 32'd9; b = 32'd9;
    tick();
    start = 1'b0;
    repeat (9) tick();
    rst = 1'b1;
    #1;
    chk("rstmid.hilo", {hi, lo}, 64'd0);
    chk("rstmid.busy", 64'(busy), 64'd0);
    chk("rstmid.done", 64'(done), 64'd0);
    chk("rstmid.stall", 64'(stall), 64'd0);
    rst = 1'b0;
    tick();
    chk("rstmid.idle", 64'(busy), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
